// File: rtl/uart_rx_multi.sv
// uart_rx_multi: oversampled UART receiver with configurable data/parity/stop bits,
// 3-sample majority vote, start-glitch rejection and parity/framing/break/overrun reporting.
module uart_rx_multi #(
    parameter int CLK_FRQ    = 250000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 data_in,
    input  logic                 rx_ready,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_break,
    output logic                 rx_overrun,
    output logic                 rx_open
);
    localparam int TICK_DIV = CLK_FRQ / (BAUD_RATE * OVERSAMPLE);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || TICK_DIV < 1) begin : g_bad_param
        $error("uart_rx_multi: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK_WAIT} state_t;

    state_t                 state;
    logic [2:0]             sync;
    logic [TW-1:0]          tcnt;
    logic [SW-1:0]          s;
    logic [IW-1:0]          idx;
    logic                   sidx;
    logic [1:0]             votes;
    logic [DATA_BITS-1:0]   shift;
    logic                   ones;
    logic                   par_err;
    logic                   frm_err;
    logic                   done;
    logic                   line;
    logic                   fall;
    logic                   tick;
    logic                   bitv;
    logic                   decide;
    logic                   bit_end;
    logic                   last_stop;

    // sync[1] is the synchronised line; sync[2] holds its previous value for edge detection
    assign line      = sync[1];
    assign fall      = sync[2] & ~sync[1];
    assign tick      = tcnt == TW'(TICK_DIV - 1);
    assign bitv      = (votes[0] & votes[1]) | (votes[0] & line) | (votes[1] & line);
    assign decide    = tick && s == SW'(OVERSAMPLE / 2 + 1);
    assign bit_end   = tick && s == SW'(OVERSAMPLE - 1);
    assign last_stop = (STOP_BITS == 1) || sidx;
    assign rx_open   = state == IDLE;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sync <= '1;
            tcnt <= '0;
        end else begin
            sync <= {sync[1:0], data_in};
            tcnt <= (tick || (state == IDLE && fall)) ? '0 : tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state         <= IDLE;
            s             <= '0;
            idx           <= '0;
            sidx          <= 1'b0;
            votes         <= '0;
            shift         <= '0;
            ones          <= 1'b0;
            par_err       <= 1'b0;
            frm_err       <= 1'b0;
            done          <= 1'b0;
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_break      <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_break   <= 1'b0;
            rx_overrun <= 1'b0;
            done       <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (tick && state != IDLE && state != BRK_WAIT) s <= bit_end ? '0 : s + 1'b1;
            if (tick && s == SW'(OVERSAMPLE / 2 - 1)) votes[0] <= line;
            if (tick && s == SW'(OVERSAMPLE / 2)) votes[1] <= line;
            case (state)
                IDLE: if (fall) begin
                    state   <= START;
                    s       <= '0;
                    idx     <= '0;
                    sidx    <= 1'b0;
                    ones    <= 1'b0;
                    par_err <= 1'b0;
                    frm_err <= 1'b0;
                end
                START: if (decide && bitv) state <= IDLE;
                    else if (bit_end) state <= DATA;
                DATA: begin
                    if (decide) begin
                        shift[idx] <= bitv;
                        ones       <= ones | bitv;
                    end
                    if (bit_end) begin
                        idx <= idx + 1'b1;
                        if (idx == IW'(DATA_BITS - 1)) state <= (PARITY != 0) ? PAR : STOP;
                    end
                end
                PAR: begin
                    if (decide) begin
                        par_err <= ^{shift, bitv} ^ (PARITY == 1);
                        ones    <= ones | bitv;
                    end
                    if (bit_end) state <= STOP;
                end
                // last stop decision returns to IDLE at once so an immediate next start is caught
                STOP: begin
                    if (decide) begin
                        frm_err <= frm_err | ~bitv;
                        ones    <= ones | bitv;
                        if (last_stop) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                    if (bit_end) sidx <= 1'b1;
                end
                BRK_WAIT: if (line) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (done) begin
                if (!ones) begin
                    rx_break <= 1'b1;
                    state    <= BRK_WAIT;
                end else if (!rx_valid || rx_ready) begin
                    rx_valid      <= 1'b1;
                    rx_data       <= shift;
                    rx_parity_err <= par_err;
                    rx_frame_err  <= frm_err;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_multi.sv
// tb_uart_rx_multi: directed checks of uart_rx_multi in 8N1, 7E1 and 8N2 configurations
// sharing one serial line; a negedge monitor logs accepted words and pulse counts per instance.
module tb_uart_rx_multi;
    localparam int BIT = 16;

    logic       clk = 1'b0;
    logic       areset;
    logic       din;
    logic       rdy[3];
    logic       vld[3];
    logic       perr[3];
    logic       ferr[3];
    logic       brk[3];
    logic       ovr[3];
    logic       opn[3];
    logic [7:0] dat0;
    logic [6:0] dat1;
    logic [7:0] dat2;
    logic [8:0] wd[3];

    logic [8:0] got_d[3][64];
    logic       got_p[3][64];
    logic       got_f[3][64];
    int         got_n[3];
    int         brk_n[3];
    int         ovr_n[3];

    int total = 0;
    int bad = 0;

    typedef struct packed {
        int         u;
        logic [8:0] d;
        logic       par;
        logic       stop;
        int         gap;
        logic [8:0] ed;
        logic       ep;
        logic       ef;
    } vec_t;

    vec_t vt[10];

    always #5 clk = ~clk;

    uart_rx_multi #(.CLK_FRQ(16000000), .BAUD_RATE(1000000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                    .OVERSAMPLE(16)) u8 (
        .clk(clk), .areset(areset), .data_in(din), .rx_ready(rdy[0]), .rx_valid(vld[0]), .rx_data(dat0),
        .rx_parity_err(perr[0]), .rx_frame_err(ferr[0]), .rx_break(brk[0]), .rx_overrun(ovr[0]), .rx_open(opn[0]));

    uart_rx_multi #(.CLK_FRQ(16000000), .BAUD_RATE(1000000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1),
                    .OVERSAMPLE(16)) u7 (
        .clk(clk), .areset(areset), .data_in(din), .rx_ready(rdy[1]), .rx_valid(vld[1]), .rx_data(dat1),
        .rx_parity_err(perr[1]), .rx_frame_err(ferr[1]), .rx_break(brk[1]), .rx_overrun(ovr[1]), .rx_open(opn[1]));

    uart_rx_multi #(.CLK_FRQ(16000000), .BAUD_RATE(1000000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2),
                    .OVERSAMPLE(16)) u2 (
        .clk(clk), .areset(areset), .data_in(din), .rx_ready(rdy[2]), .rx_valid(vld[2]), .rx_data(dat2),
        .rx_parity_err(perr[2]), .rx_frame_err(ferr[2]), .rx_break(brk[2]), .rx_overrun(ovr[2]), .rx_open(opn[2]));

    assign wd[0] = {1'b0, dat0};
    assign wd[1] = {2'b0, dat1};
    assign wd[2] = {1'b0, dat2};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vld[i] && rdy[i] && got_n[i] < 64) begin
                got_d[i][got_n[i]] <= wd[i];
                got_p[i][got_n[i]] <= perr[i];
                got_f[i][got_n[i]] <= ferr[i];
                got_n[i]           <= got_n[i] + 1;
            end
            if (brk[i]) brk_n[i] <= brk_n[i] + 1;
            if (ovr[i]) ovr_n[i] <= ovr_n[i] + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bit_out(input logic b);
        din = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input int u, input logic [8:0] d, input logic par, input logic stop, input int gap);
        int nbits;
        nbits = (u == 1) ? 7 : 8;
        for (int i = 0; i < gap; i++) bit_out(1'b1);
        bit_out(1'b0);
        for (int i = 0; i < nbits; i++) bit_out(d[i]);
        if (u == 1) bit_out(par);
        for (int i = 0; i < ((u == 2) ? 2 : 1); i++) bit_out(stop);
        din = 1'b1;
    endtask

    task automatic wait_word(input int u, input int base);
        int k;
        k = 0;
        while (got_n[u] <= base && k < 64) begin
            @(negedge clk);
            k++;
        end
        if (got_n[u] <= base) begin
            total++;
            bad++;
            $display("FAIL wait_word u%0d: no word within %0d cycles", u, k);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int base, b0, o0;
        vt[0] = '{0, 9'h0A5, 1'b0, 1'b1, 2, 9'h0A5, 1'b0, 1'b0};
        vt[1] = '{0, 9'h03C, 1'b0, 1'b1, 0, 9'h03C, 1'b0, 1'b0};
        vt[2] = '{1, 9'h041, 1'b1, 1'b1, 2, 9'h041, 1'b1, 1'b0};
        vt[3] = '{1, 9'h041, 1'b0, 1'b1, 1, 9'h041, 1'b0, 1'b0};
        vt[4] = '{1, 9'h07F, 1'b1, 1'b1, 1, 9'h07F, 1'b0, 1'b0};
        vt[5] = '{1, 9'h000, 1'b1, 1'b1, 1, 9'h000, 1'b1, 1'b0};
        vt[6] = '{0, 9'h055, 1'b0, 1'b0, 2, 9'h055, 1'b0, 1'b1};
        vt[7] = '{0, 9'h000, 1'b0, 1'b1, 2, 9'h000, 1'b0, 1'b0};
        vt[8] = '{0, 9'h080, 1'b0, 1'b1, 1, 9'h080, 1'b0, 1'b0};
        vt[9] = '{1, 9'h02A, 1'b1, 1'b0, 1, 9'h02A, 1'b0, 1'b1};
        areset = 1'b1;
        din = 1'b1;
        for (int i = 0; i < 3; i++) rdy[i] = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_valid", vld[0], 0);
        chk("rst_open", opn[0], 1);
        chk("rst_data", wd[0], 0);
        chk("rst_perr", perr[0], 0);
        chk("rst_ferr", ferr[0], 0);
        chk("rst_break", brk[0], 0);
        chk("rst_overrun", ovr[0], 0);
        chk("rst_open_u7", opn[1], 1);
        areset = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            base = got_n[vt[i].u];
            send_frame(vt[i].u, vt[i].d, vt[i].par, vt[i].stop, vt[i].gap);
            wait_word(vt[i].u, base);
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_count", i), got_n[vt[i].u] - base, 1);
            chk($sformatf("v%0d_data", i), got_d[vt[i].u][base], vt[i].ed);
            chk($sformatf("v%0d_perr", i), got_p[vt[i].u][base], vt[i].ep);
            chk($sformatf("v%0d_ferr", i), got_f[vt[i].u][base], vt[i].ef);
            chk($sformatf("v%0d_valid_low", i), vld[vt[i].u], 0);
        end

        bit_out(1'b1);
        bit_out(1'b1);
        base = got_n[0];
        din = 1'b0;
        repeat (4) @(negedge clk);
        din = 1'b1;
        repeat (3) @(negedge clk);
        chk("glitch_seen", opn[0], 0);
        repeat (BIT) @(negedge clk);
        chk("glitch_open", opn[0], 1);
        chk("glitch_noword", got_n[0] - base, 0);

        bit_out(1'b1);
        base = got_n[0];
        b0 = brk_n[0];
        din = 1'b0;
        repeat (12 * BIT) @(negedge clk);
        chk("brk_pulse", brk_n[0] - b0, 1);
        chk("brk_noword", got_n[0] - base, 0);
        chk("brk_wait_open", opn[0], 0);
        send_frame(0, 9'h012, 1'b0, 1'b1, 2);
        wait_word(0, base);
        chk("brk_next_data", got_d[0][base], 9'h012);
        chk("brk_next_count", got_n[0] - base, 1);

        rdy[0] = 1'b0;
        base = got_n[0];
        o0 = ovr_n[0];
        send_frame(0, 9'h011, 1'b0, 1'b1, 2);
        send_frame(0, 9'h022, 1'b0, 1'b1, 1);
        repeat (4) @(negedge clk);
        chk("ovr_pulse", ovr_n[0] - o0, 1);
        chk("ovr_valid_held", vld[0], 1);
        chk("ovr_data_held", wd[0], 9'h011);
        chk("ovr_no_accept", got_n[0] - base, 0);
        @(posedge clk);
        #1 rdy[0] = 1'b1;
        wait_word(0, base);
        repeat (3) @(negedge clk);
        chk("ovr_accept_data", got_d[0][base], 9'h011);
        chk("ovr_accept_count", got_n[0] - base, 1);
        chk("ovr_valid_cleared", vld[0], 0);

        areset = 1'b1;
        repeat (2) @(negedge clk);
        areset = 1'b0;
        base = got_n[2];
        b0 = brk_n[2];
        o0 = ovr_n[2];
        bit_out(1'b1);
        bit_out(1'b1);
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(1'b0);
        din = 1'b1;
        repeat (6) @(negedge clk);
        chk("arst_busy", opn[2], 0);
        areset = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_open", opn[2], 1);
        chk("arst_valid", vld[2], 0);
        areset = 1'b0;
        repeat (4 * BIT) @(negedge clk);
        send_frame(2, 9'h00F, 1'b0, 1'b1, 1);
        wait_word(2, base);
        repeat (3) @(negedge clk);
        chk("arst_count", got_n[2] - base, 1);
        chk("arst_data", got_d[2][base], 9'h00F);
        chk("arst_ferr", got_f[2][base], 0);
        chk("arst_no_break", brk_n[2] - b0, 0);
        chk("arst_no_overrun", ovr_n[2] - o0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
